// File: rtl/mlp_axil_regs.sv
// AXI4-Lite register block for the MLP core: START/TOGGLE control levels, READY/CL_NUM status.
// Latency: write response one cycle after both AW and W are held; read data one cycle after AR.
// Backpressure: awready/wready drop while a channel is held or bvalid is pending; arready drops while rvalid.
module mlp_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            start_o,
    output logic                            toggle_o,
    input  logic                            ready_i,
    input  logic [3:0]                      cl_num_i
);

    localparam logic [1:0] IDX_START  = 2'd0;
    localparam logic [1:0] IDX_READY  = 2'd1;
    localparam logic [1:0] IDX_TOGGLE = 2'd2;
    localparam logic [1:0] IDX_CL_NUM = 2'd3;

    logic                          aw_held_q, aw_held_d;
    logic                          w_held_q, w_held_d;
    logic [1:0]                    aw_idx_q, aw_idx_d;
    logic                          w_bit0_q, w_bit0_d;
    logic                          w_strb0_q, w_strb0_d;
    logic                          bvalid_q, bvalid_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                          start_q, start_d;
    logic                          toggle_q, toggle_d;
    logic                          ready_sticky_q, ready_sticky_d;
    logic [3:0]                    cl_num_q, cl_num_d;

    logic                          aw_fire, w_fire, ar_fire, do_write;
    logic [1:0]                    wr_idx, rd_idx;
    logic                          wr_bit0, wr_strb0;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;

    // Protection bits, byte lanes above 0 and data bits above 0 carry nothing for this map.
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:1],
                         s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

    // Ready signals are forced low while reset is asserted so the bus sees an idle slave.
    assign s00_axi_awready = s00_axi_aresetn && !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = s00_axi_aresetn && !w_held_q && !bvalid_q;
    assign s00_axi_arready = s00_axi_aresetn && !rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;
    assign start_o         = start_q;
    assign toggle_o        = toggle_q;

    // Next-state for write capture, register update, status capture and read return.
    always_comb begin
        aw_held_d      = aw_held_q;
        w_held_d       = w_held_q;
        aw_idx_d       = aw_idx_q;
        w_bit0_d       = w_bit0_q;
        w_strb0_d      = w_strb0_q;
        bvalid_d       = bvalid_q;
        rvalid_d       = rvalid_q;
        rdata_d        = rdata_q;
        start_d        = start_q;
        toggle_d       = toggle_q;
        ready_sticky_d = ready_sticky_q;
        cl_num_d       = cl_num_i;

        aw_fire  = s00_axi_awvalid && s00_axi_awready;
        w_fire   = s00_axi_wvalid && s00_axi_wready;
        ar_fire  = s00_axi_arvalid && s00_axi_arready;
        // A channel arriving this cycle is used directly so same-cycle AW/W completes at once.
        wr_idx   = aw_held_q ? aw_idx_q : s00_axi_awaddr[3:2];
        wr_bit0  = w_held_q ? w_bit0_q : s00_axi_wdata[0];
        wr_strb0 = w_held_q ? w_strb0_q : s00_axi_wstrb[0];
        do_write = (aw_held_q || aw_fire) && (w_held_q || w_fire);
        rd_idx   = s00_axi_araddr[3:2];

        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
        end
        if (w_fire) begin
            w_held_d  = 1'b1;
            w_bit0_d  = s00_axi_wdata[0];
            w_strb0_d = s00_axi_wstrb[0];
        end

        if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (do_write) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (wr_strb0 && wr_idx == IDX_START) begin
                start_d = wr_bit0;
                if (wr_bit0) begin
                    ready_sticky_d = 1'b0;
                end
            end
            if (wr_strb0 && wr_idx == IDX_TOGGLE) begin
                toggle_d = wr_bit0;
            end
        end
        // Setting has priority over a START-triggered clear in the same cycle.
        if (ready_i) begin
            ready_sticky_d = 1'b1;
        end

        // Read mux uses current register values, so a same-cycle write is not visible.
        rd_val = '0;
        case (rd_idx)
            IDX_START:  rd_val[0]   = start_q;
            IDX_READY:  rd_val[0]   = ready_sticky_q;
            IDX_TOGGLE: rd_val[0]   = toggle_q;
            IDX_CL_NUM: rd_val[3:0] = cl_num_q;
            default:    rd_val      = '0;
        endcase

        if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
            rdata_d  = '0;
        end
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            aw_idx_q       <= 2'd0;
            w_bit0_q       <= 1'b0;
            w_strb0_q      <= 1'b0;
            bvalid_q       <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            start_q        <= 1'b0;
            toggle_q       <= 1'b0;
            ready_sticky_q <= 1'b0;
            cl_num_q       <= 4'd0;
        end else begin
            aw_held_q      <= aw_held_d;
            w_held_q       <= w_held_d;
            aw_idx_q       <= aw_idx_d;
            w_bit0_q       <= w_bit0_d;
            w_strb0_q      <= w_strb0_d;
            bvalid_q       <= bvalid_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            start_q        <= start_d;
            toggle_q       <= toggle_d;
            ready_sticky_q <= ready_sticky_d;
            cl_num_q       <= cl_num_d;
        end
    end

endmodule
